// File: rtl/encoder_pkg.sv
// Shared types and defaults for the encoder sampling/homing path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package encoder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEEK_Z = 2'd1,
        RUN    = 2'd2
    } sched_state_t;

    // Direction codes from the quadrature decoder
    localparam logic [1:0] DIR_CW  = 2'b01;  // A leads: position counts down
    localparam logic [1:0] DIR_CCW = 2'b10;  // B leads: position counts up

    localparam int ENCO_NUM_DEF   = 4000;
    localparam int SAMPLE_DIV_DEF = 50000;
    localparam int CNT_W_DEF      = 16;

endpackage

// File: rtl/sample_window_timer.sv
// Modulo-DIV window counter producing a one-cycle tick on its last count.
// Latency: tick is combinational from the count; DIV enabled cycles per window.
// Backpressure: none; clr holds the count at zero and wins over en.
module sample_window_timer #(
    parameter int DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    // Window count: wraps to zero after LAST, held at zero while cleared
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/encoder_sample_sched.sv
// Homing sequencer and single-turn position tracker emitting per-window velocity samples.
// Latency: Z->homed 1 cycle; window tick at cycle T -> sample visible at T+1.
// Backpressure: s_valid holds until accepted; a new tick overwrites unread data and sets overrun.
module encoder_sample_sched
    import encoder_pkg::*;
#(
    parameter int SAMPLE_DIV = SAMPLE_DIV_DEF,
    parameter int ENCO_NUM   = ENCO_NUM_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enc_pulse,
    input  logic [1:0]       enc_dir,
    input  logic             enc_z_pos,
    input  logic             home_req,
    input  logic             s_ready,
    output logic             s_valid,
    output logic [CNT_W-1:0] s_delta,
    output logic [CNT_W-1:0] s_pos,
    output logic             homed,
    output logic             home_busy,
    output logic             overrun,
    output logic             z_err
);

    localparam logic [CNT_W-1:0]        POS_LAST = CNT_W'(ENCO_NUM - 1);
    localparam logic signed [CNT_W-1:0] ACC_MAX  = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic signed [CNT_W-1:0] ACC_MIN  = {1'b1, {(CNT_W-1){1'b0}}};

    sched_state_t state, state_nxt;

    logic                    run;
    logic                    tick;
    logic                    step_up;
    logic                    step_dn;
    logic [CNT_W-1:0]        pos;
    logic [CNT_W-1:0]        pos_step;
    logic [CNT_W-1:0]        pos_nxt;
    logic signed [CNT_W-1:0] acc;
    logic signed [CNT_W-1:0] acc_nxt;

    assign run     = (state == RUN);
    assign step_up = run && enc_pulse && (enc_dir == DIR_CCW);
    assign step_dn = run && enc_pulse && (enc_dir == DIR_CW);

    // Timebase only runs in RUN, so entering RUN always starts a fresh window
    sample_window_timer #(
        .DIV (SAMPLE_DIV)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .en   (run),
        .clr  (!run),
        .tick (tick)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: home_req (re)starts homing, Z completes it
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (home_req)  state_nxt = SEEK_Z;
            SEEK_Z:  if (enc_z_pos) state_nxt = RUN;
            RUN:     if (home_req)  state_nxt = SEEK_Z;
            default: state_nxt = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        home_busy = (state == SEEK_Z);
    end

    // Position/accumulator next values; Z overrides position but not the accumulator
    always_comb begin
        pos_step = pos;
        if (step_up) begin
            pos_step = (pos == POS_LAST) ? '0 : pos + 1'b1;
        end else if (step_dn) begin
            pos_step = (pos == '0) ? POS_LAST : pos - 1'b1;
        end
        pos_nxt = enc_z_pos ? '0 : pos_step;

        acc_nxt = acc;
        if (step_up && (acc != ACC_MAX)) begin
            acc_nxt = acc + 1'b1;
        end else if (step_dn && (acc != ACC_MIN)) begin
            acc_nxt = acc - 1'b1;
        end
    end

    // Datapath, sample register and sticky flags; home_req cancels any same-cycle tick
    always_ff @(posedge clk) begin
        if (rst) begin
            pos     <= '0;
            acc     <= '0;
            homed   <= 1'b0;
            s_valid <= 1'b0;
            s_delta <= '0;
            s_pos   <= '0;
            overrun <= 1'b0;
            z_err   <= 1'b0;
        end else begin
            if (home_req) begin
                homed   <= 1'b0;
                s_valid <= 1'b0;
                overrun <= 1'b0;
                z_err   <= 1'b0;
            end
            case (state)
                SEEK_Z: begin
                    if (enc_z_pos) begin
                        pos   <= '0;
                        acc   <= '0;
                        homed <= 1'b1;
                    end
                end
                RUN: begin
                    if (!home_req) begin
                        pos <= pos_nxt;
                        if (enc_z_pos && (pos != '0)) begin
                            z_err <= 1'b1;
                        end
                        if (tick) begin
                            s_delta <= acc_nxt;
                            s_pos   <= pos_nxt;
                            acc     <= '0;
                            s_valid <= 1'b1;
                            if (s_valid && !s_ready) begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            acc <= acc_nxt;
                            if (s_valid && s_ready) begin
                                s_valid <= 1'b0;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_encoder_sample_sched.sv
// Self-checking bench: directed windows from the test plan plus randomized traffic vs. a reference model.
// Latency: model is updated at each rising edge and compared 1 time unit later.
// Backpressure: s_ready is driven per window (accept / stall) and randomly in the random phase.
module tb_encoder_sample_sched;

    localparam int DIV = 200;
    localparam int N   = 50;
    localparam int W   = 8;
    localparam int AMAX = (1 << (W - 1)) - 1;
    localparam int AMIN = -(1 << (W - 1));

    logic         clk = 1'b0;
    logic         rst;
    logic         enc_pulse;
    logic [1:0]   enc_dir;
    logic         enc_z_pos;
    logic         home_req;
    logic         s_ready;
    logic         s_valid;
    logic [W-1:0] s_delta;
    logic [W-1:0] s_pos;
    logic         homed;
    logic         home_busy;
    logic         overrun;
    logic         z_err;

    always #5 clk = ~clk;

    encoder_sample_sched #(
        .SAMPLE_DIV (DIV),
        .ENCO_NUM   (N),
        .CNT_W      (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enc_pulse (enc_pulse),
        .enc_dir   (enc_dir),
        .enc_z_pos (enc_z_pos),
        .home_req  (home_req),
        .s_ready   (s_ready),
        .s_valid   (s_valid),
        .s_delta   (s_delta),
        .s_pos     (s_pos),
        .homed     (homed),
        .home_busy (home_busy),
        .overrun   (overrun),
        .z_err     (z_err)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: mode 0=idle 1=seeking Z 2=running
    int m_mode  = 0;
    int m_pos   = 0;
    int m_acc   = 0;
    int m_delta = 0;
    int m_spos  = 0;
    int m_start = 0;
    int cyc     = 0;
    bit m_homed = 0;
    bit m_valid = 0;
    bit m_ovr   = 0;
    bit m_zerr  = 0;

    task automatic chk(input string tag, input integer obs, input integer exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_step();
        int d;
        cyc++;
        if (rst) begin
            m_mode = 0; m_pos = 0; m_acc = 0; m_delta = 0; m_spos = 0;
            m_homed = 0; m_valid = 0; m_ovr = 0; m_zerr = 0;
            return;
        end
        if (home_req) begin
            m_homed = 0; m_valid = 0; m_ovr = 0; m_zerr = 0;
        end
        case (m_mode)
            0: if (home_req) m_mode = 1;
            1: if (enc_z_pos) begin
                   m_pos = 0; m_acc = 0; m_homed = 1; m_start = cyc; m_mode = 2;
               end
            default: begin
                if (home_req) begin
                    m_mode = 1;
                end else begin
                    d = 0;
                    if (enc_pulse && enc_dir == 2'b10) d = 1;
                    if (enc_pulse && enc_dir == 2'b01) d = -1;
                    if (enc_z_pos) begin
                        if (m_pos != 0) m_zerr = 1;
                        m_pos = 0;
                    end else begin
                        m_pos = (m_pos + d + N) % N;
                    end
                    m_acc = m_acc + d;
                    if (m_acc > AMAX) m_acc = AMAX;
                    if (m_acc < AMIN) m_acc = AMIN;
                    if ((cyc - m_start) % DIV == 0) begin
                        if (m_valid && !s_ready) m_ovr = 1;
                        m_valid = 1;
                        m_delta = m_acc;
                        m_spos  = m_pos;
                        m_acc   = 0;
                    end else if (m_valid && s_ready) begin
                        m_valid = 0;
                    end
                end
            end
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        chk("s_valid",   s_valid,          m_valid);
        chk("s_delta",   $signed(s_delta), m_delta);
        chk("s_pos",     s_pos,            m_spos);
        chk("homed",     homed,            m_homed);
        chk("home_busy", home_busy,        (m_mode == 1));
        chk("overrun",   overrun,          m_ovr);
        chk("z_err",     z_err,            m_zerr);
    endtask

    task automatic idle_inputs();
        rst = 0; enc_pulse = 0; enc_dir = 2'b00; enc_z_pos = 0; home_req = 0; s_ready = 0;
    endtask

    // One full window of DIV cycles: nup up-pulses, then ndn down-pulses, Z at index zat
    task automatic run_window(input int nup, input int ndn, input int zat,
                              input bit first_rdy, input bit rest_rdy);
        for (int i = 0; i < DIV; i++) begin
            enc_pulse = (i < nup + ndn);
            enc_dir   = (i < nup) ? 2'b10 : 2'b01;
            enc_z_pos = (i == zat);
            home_req  = 0;
            s_ready   = (i == 0) ? first_rdy : rest_rdy;
            step();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        repeat (3) step();
        chk("rst_valid", s_valid, 0);
        chk("rst_delta", s_delta, 0);
        chk("rst_pos",   s_pos,   0);
        chk("rst_busy",  home_busy, 0);
        rst = 0;

        // Pulses in IDLE and SEEK_Z are ignored
        enc_pulse = 1; enc_dir = 2'b10;
        repeat (5) step();
        home_req = 1; step(); home_req = 0;
        chk("seek_busy", home_busy, 1);
        repeat (3) step();

        // Z with a same-cycle pulse: pulse discarded, homed next cycle
        enc_z_pos = 1; step();
        idle_inputs();
        chk("z_homed", homed, 1);
        chk("z_busy",  home_busy, 0);

        // First window, no pulses
        run_window(0, 0, -1, 0, 0);
        chk("w0_valid", s_valid, 1);
        chk("w0_delta", $signed(s_delta), 0);
        chk("w0_pos",   s_pos, 0);

        run_window(37, 5, -1, 1, 1);
        chk("w1_delta", $signed(s_delta), 32);
        chk("w1_pos",   s_pos, 32);

        run_window(0, 32, -1, 1, 1);
        chk("w2_delta", $signed(s_delta), -32);
        chk("w2_pos",   s_pos, 0);

        run_window(0, 3, -1, 1, 1);
        chk("wrap_delta", $signed(s_delta), -3);
        chk("wrap_pos",   s_pos, N - 3);

        // Two unread ticks
        run_window(2, 0, -1, 1, 0);
        chk("ovr_pre", overrun, 0);
        run_window(4, 0, -1, 0, 0);
        chk("ovr_set",   overrun, 1);
        chk("ovr_delta", $signed(s_delta), 4);
        chk("ovr_pos",   s_pos, 3);
        s_ready = 1; step(); s_ready = 0;
        chk("acc_drop",  s_valid, 0);
        chk("ovr_hold",  overrun, 1);
        repeat (5) step();
        chk("ovr_stick", overrun, 1);
        home_req = 1; step(); home_req = 0;
        chk("ovr_clr",   overrun, 0);
        chk("rehome",    homed, 0);
        enc_z_pos = 1; step(); enc_z_pos = 0;

        // Z at position 10 with a same-cycle up pulse
        run_window(11, 0, 10, 1, 1);
        chk("zerr_set",   z_err, 1);
        chk("zerr_delta", $signed(s_delta), 11);
        chk("zerr_pos",   s_pos, 0);

        // Saturation both ways
        run_window(0, 140, -1, 1, 1);
        chk("sat_lo", $signed(s_delta), AMIN);
        chk("sat_lo_pos", s_pos, 10);
        run_window(140, 0, -1, 1, 1);
        chk("sat_hi", $signed(s_delta), AMAX);
        chk("sat_hi_pos", s_pos, 0);

        // Reset mid-window aborts everything
        s_ready = 1; enc_pulse = 1; enc_dir = 2'b10;
        repeat (60) step();
        rst = 1; step();
        idle_inputs();
        chk("abort_valid", s_valid, 0);
        chk("abort_homed", homed, 0);
        chk("abort_zerr",  z_err, 0);
        chk("abort_delta", s_delta, 0);
        repeat (DIV + 20) step();
        chk("abort_quiet", s_valid, 0);

        // Randomized traffic
        home_req = 1; step(); home_req = 0;
        for (int i = 0; i < 4000; i++) begin
            rst       = ($urandom_range(0, 1999) == 0);
            home_req  = ($urandom_range(0, 299) == 0);
            enc_z_pos = ($urandom_range(0, 79) == 0);
            enc_pulse = ($urandom_range(0, 3) != 0);
            enc_dir   = 2'($urandom_range(0, 3));
            s_ready   = ($urandom_range(0, 3) != 0);
            if (i % 700 == 0) home_req = 1;
            step();
        end
        idle_inputs();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/encoder_sample_sched.md
# encoder_sample_sched

Periodic sampling and homing controller for the quadrature encoder front end. Consumes the 4x pulse strobe, direction code and Z-index edge from the encoder decoder, sequences a homing cycle, and maintains a single-turn position. Once homed, it emits a fixed-rate stream of velocity samples to the DSP interface over a valid/ready handshake.

## Interface
- `SAMPLE_DIV`, 50000: clocks per sample window (1 ms at 50 MHz); legal range ≥ 2.
- `ENCO_NUM`, 4000: 4x pulses per revolution; legal range 2..32767.
- `CNT_W`, 16: width of position and delta outputs.
- `clk`  in  1  system clock; everything is on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `enc_pulse`  in  1  one-cycle 4x quadrature strobe.
- `enc_dir`  in  2  direction code: 01 = A leads (count down), 10 = B leads (count up), 00/11 = unknown.
- `enc_z_pos`  in  1  one-cycle Z-index rising-edge strobe.
- `home_req`  in  1  one-cycle request to (re)start homing.
- `s_ready`  in  1  DSP side accepts a sample.
- `s_valid`  out  1  sample available.
- `s_delta`  out  CNT_W  signed pulse count over the last window.
- `s_pos`  out  CNT_W  unsigned single-turn position latched at window end.
- `homed`  out  1  position referenced to Z.
- `home_busy`  out  1  waiting for Z.
- `overrun`  out  1  sticky: an unread sample was overwritten.
- `z_err`  out  1  sticky: Z seen while position ≠ 0.

## Operation
- States are IDLE, SEEK_Z and RUN. Reset enters IDLE.
- IDLE:
  - On `home_req`, go to SEEK_Z.
  - Pulses are ignored.
- SEEK_Z (`home_busy`=1):
  - On `enc_z_pos`: position ← 0, accumulator ← 0, window counter ← 0, `homed` ← 1, go to RUN.
  - A pulse arriving in the same cycle as Z is discarded.
- RUN:
  - Pulse with `enc_dir`=10: position +1, wrapping ENCO_NUM-1 → 0.
  - Pulse with `enc_dir`=01: position −1, wrapping 0 → ENCO_NUM-1.
  - Pulse with `enc_dir` 00/11: ignored.
  - Accumulator takes the same ±1 and saturates at +32767 / −32768 (CNT_W=16).
  - `enc_z_pos` in RUN:
    - If the pre-update position ≠ 0, set `z_err`.
    - Then position ← 0. Z takes priority over a same-cycle pulse for position.
    - The accumulator still counts that pulse.
  - `home_req` in RUN: go to SEEK_Z, clear `homed`, `s_valid`, `overrun` and `z_err`.
- Window tick:
  - Occurs when the window counter = SAMPLE_DIV-1 in RUN; the counter then returns to 0.
  - `s_delta` ← accumulator including any same-cycle pulse.
  - `s_pos` ← post-update position.
  - The accumulator restarts at 0.
- Handshake:
  - `s_valid` holds until `s_valid & s_ready`.
  - Data is stable while `s_valid` is high and unaccepted.
  - Tick while `s_valid=1` and `s_ready=0`: overwrite the data, keep `s_valid`, set `overrun`.
  - Tick in the same cycle as an accepting `s_ready`: load the new data, `s_valid` stays 1, no overrun.
- Sticky flags clear only on `rst` or `home_req`.

## Timing
- Every output resets to 0. State resets to IDLE; counter, accumulator and position reset to 0.
- Z → `homed`=1: 1 cycle (registered).
- Tick cycle T → `s_valid`/data visible at T+1.
- First tick is SAMPLE_DIV cycles after the Z that entered RUN.
- Accept at cycle A → `s_valid`=0 at A+1, unless a tick occurred at A.
- Pulses are processed every cycle with no loss, including pulses on consecutive cycles.
- `rst` mid-window or mid-handshake aborts immediately: no sample is emitted and state returns to IDLE.

## Structure
- Shared package `encoder_pkg`:
  - State enum `{IDLE, SEEK_Z, RUN}`.
  - Direction constants `DIR_CW=2'b01`, `DIR_CCW=2'b10`.
  - `ENCO_NUM` default.
- One natural sub-module, `sample_window_timer`:
  - Modulo-SAMPLE_DIV counter with `en`/`clr` inputs and a one-cycle `tick` output.
  - Keeps the FSM/handshake logic separate from the timebase.

## Test plan
- Reset, then `home_req`, then Z; no pulses → `homed`=1 at Z+1, first `s_valid` at Z+SAMPLE_DIV+1 with `s_delta`=0, `s_pos`=0.
- SAMPLE_DIV=100, 37 pulses dir=10 then 5 pulses dir=01 in window 1, `s_ready`=1 → `s_delta`=32, `s_pos`=32.
- From position 0, 3 pulses dir=01 with ENCO_NUM=4000 → `s_pos`=3997, `s_delta`=−3.
- `s_ready`=0 across two ticks → `overrun`=1, `s_delta` shows window 2 only; assert `s_ready` → `s_valid` drops next cycle, `overrun` stays 1 until `home_req`.
- In RUN at position 10, Z with a same-cycle dir=10 pulse → `z_err`=1, position 0, accumulator +1 in the next sample.
- 40000 dir=10 pulses in one window at ENCO_NUM=4000 → `s_delta`=32767 (saturated), `s_pos`=0; `rst` asserted mid-next-window → all outputs 0, IDLE, no sample emitted.
